// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I sequencer: latches instructions from a shared memory port and steps FETCH/DECODE/EXECUTE/MEM/WB.
// Latency: branch 3, ALU/LUI/JAL/JALR/store 4, load 5 cycles with zero memory wait; each wait cycle adds one.
// Backpressure: FETCH and MEM hold mem_req (and its address/write qualifiers) steady until mem_ready.
module multicycle_controller #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] instr,
    input  logic            mem_ready,
    input  logic            alu_zero,
    output logic [XLEN-1:0] ir,
    output logic [6:0]      opcode,
    output logic [11:0]     imm_input,
    output logic [19:0]     imm_input_uj,
    output logic            mem_req,
    output logic            mem_we,
    output logic            mem_addr_sel,
    output logic            pc_write,
    output logic [1:0]      pc_src,
    output logic            alu_src_b,
    output logic            reg_write,
    output logic [1:0]      wb_sel,
    output logic [2:0]      state,
    output logic            illegal
);

    typedef enum logic [2:0] {
        ST_FETCH   = 3'd0,
        ST_DECODE  = 3'd1,
        ST_EXECUTE = 3'd2,
        ST_MEM     = 3'd3,
        ST_WB      = 3'd4,
        ST_HALT    = 3'd5
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    // Reset value of the instruction register: ADDI x0,x0,0.
    localparam logic [XLEN-1:0] IR_NOP = 32'h0000_0013;

    state_t cur;

    logic is_r, is_ialu, is_load, is_store, is_branch, is_jal, is_jalr, is_lui;
    logic branch_ok, legal, branch_taken;

    assign state  = cur;
    assign opcode = ir[6:0];

    assign is_r      = (ir[6:0] == OP_R);
    assign is_ialu   = (ir[6:0] == OP_IALU);
    assign is_load   = (ir[6:0] == OP_LOAD);
    assign is_store  = (ir[6:0] == OP_STORE);
    assign is_branch = (ir[6:0] == OP_BRANCH);
    assign is_jal    = (ir[6:0] == OP_JAL);
    assign is_jalr   = (ir[6:0] == OP_JALR);
    assign is_lui    = (ir[6:0] == OP_LUI);

    // Only BEQ (000) and BNE (001) are implemented; funct3[0] selects the sense.
    assign branch_ok    = is_branch && (ir[14:13] == 2'b00);
    assign branch_taken = ir[12] ? !alu_zero : alu_zero;
    assign legal        = is_r || is_ialu || is_load || is_store || branch_ok ||
                          is_jal || is_jalr || is_lui;

    // Sequencer state, instruction register and sticky illegal flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            cur     <= ST_FETCH;
            ir      <= IR_NOP;
            illegal <= 1'b0;
        end else begin
            case (cur)
                ST_FETCH: begin
                    if (mem_ready) begin
                        ir  <= instr;
                        cur <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    if (!legal) begin
                        illegal <= 1'b1;
                        cur     <= ST_HALT;
                    end else begin
                        cur <= ST_EXECUTE;
                    end
                end
                ST_EXECUTE: begin
                    if (is_branch)
                        cur <= ST_FETCH;
                    else if (is_load || is_store)
                        cur <= ST_MEM;
                    else
                        cur <= ST_WB;
                end
                ST_MEM: begin
                    if (mem_ready)
                        cur <= is_store ? ST_FETCH : ST_WB;
                end
                ST_WB:   cur <= ST_FETCH;
                ST_HALT: cur <= ST_HALT;
                default: cur <= ST_FETCH;
            endcase
        end
    end

    // Immediate field extraction in the layout imm_generator expects; unused field stays 0.
    always_comb begin
        imm_input    = '0;
        imm_input_uj = '0;
        case (ir[6:0])
            OP_IALU, OP_LOAD, OP_JALR: imm_input = ir[31:20];
            OP_STORE:  imm_input    = {ir[31:25], ir[11:7]};
            OP_BRANCH: imm_input    = {ir[31], ir[7], ir[30:25], ir[11:8]};
            OP_JAL:    imm_input_uj = {ir[31], ir[19:12], ir[20], ir[30:21]};
            OP_LUI:    imm_input_uj = ir[31:12];
            default:   ;
        endcase
    end

    // Per-state control strobes; everything is held low while reset is asserted.
    always_comb begin
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        pc_write     = 1'b0;
        pc_src       = 2'd0;
        alu_src_b    = 1'b0;
        reg_write    = 1'b0;
        wb_sel       = 2'd0;
        if (!reset) begin
            case (cur)
                ST_FETCH: begin
                    mem_req = 1'b1;
                end
                ST_EXECUTE: begin
                    alu_src_b = is_ialu || is_load || is_store || is_jalr;
                    if (is_branch) begin
                        pc_write = 1'b1;
                        pc_src   = branch_taken ? 2'd1 : 2'd0;
                    end
                end
                ST_MEM: begin
                    mem_req      = 1'b1;
                    mem_addr_sel = 1'b1;
                    mem_we       = is_store;
                    // A store retires on its memory handshake; a load retires in WB.
                    pc_write     = is_store && mem_ready;
                end
                ST_WB: begin
                    reg_write = 1'b1;
                    pc_write  = 1'b1;
                    if (is_load) begin
                        wb_sel = 2'd1;
                    end else if (is_jal) begin
                        wb_sel = 2'd2;
                        pc_src = 2'd1;
                    end else if (is_jalr) begin
                        wb_sel = 2'd2;
                        pc_src = 2'd2;
                    end else if (is_lui) begin
                        wb_sel = 2'd3;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: directed instruction scenarios plus random instruction streams
// with random memory wait states, checked cycle by cycle against a phase-list reference model.
module tb_multicycle_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr;
    logic        mem_ready;
    logic        alu_zero;
    logic [31:0] ir;
    logic [6:0]  opcode;
    logic [11:0] imm_input;
    logic [19:0] imm_input_uj;
    logic        mem_req, mem_we, mem_addr_sel, pc_write, alu_src_b, reg_write, illegal;
    logic [1:0]  pc_src, wb_sel;
    logic [2:0]  state;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state and observations captured for directed checks.
    logic [31:0] model_ir;
    logic [11:0] obs_imm12;
    logic [19:0] obs_imm20;
    logic [6:0]  obs_opc;
    logic        obs_asb;
    logic [1:0]  obs_wb, obs_ps;
    logic        obs_rw;
    int          obs_mem_cycles;

    logic [13:0] ctrl;
    assign ctrl = {state, mem_req, mem_we, mem_addr_sel, pc_write, pc_src,
                   alu_src_b, reg_write, wb_sel, illegal};

    always #5 clk = ~clk;

    multicycle_controller #(.XLEN(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .instr        (instr),
        .mem_ready    (mem_ready),
        .alu_zero     (alu_zero),
        .ir           (ir),
        .opcode       (opcode),
        .imm_input    (imm_input),
        .imm_input_uj (imm_input_uj),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr_sel (mem_addr_sel),
        .pc_write     (pc_write),
        .pc_src       (pc_src),
        .alu_src_b    (alu_src_b),
        .reg_write    (reg_write),
        .wb_sel       (wb_sel),
        .state        (state),
        .illegal      (illegal)
    );

    typedef enum int {K_R, K_I, K_LD, K_ST, K_BR, K_JAL, K_JALR, K_LUI, K_BAD} kind_t;

    function automatic kind_t kind_of(input logic [31:0] x);
        case (x[6:0])
            7'b0110011: return K_R;
            7'b0010011: return K_I;
            7'b0000011: return K_LD;
            7'b0100011: return K_ST;
            7'b1100011: return (x[14:12] == 3'b000 || x[14:12] == 3'b001) ? K_BR : K_BAD;
            7'b1101111: return K_JAL;
            7'b1100111: return K_JALR;
            7'b0110111: return K_LUI;
            default:    return K_BAD;
        endcase
    endfunction

    // Expected {imm_input, imm_input_uj} for an instruction word.
    function automatic logic [31:0] exp_imm(input logic [31:0] x);
        logic [11:0] a = '0;
        logic [19:0] b = '0;
        case (x[6:0])
            7'b0010011, 7'b0000011, 7'b1100111: a = x[31:20];
            7'b0100011: a = {x[31:25], x[11:7]};
            7'b1100011: a = {x[31], x[7], x[30:25], x[11:8]};
            7'b1101111: b = {x[31], x[19:12], x[20], x[30:21]};
            7'b0110111: b = x[31:12];
            default: ;
        endcase
        return {a, b};
    endfunction

    // Expected control vector for a phase (0 FETCH .. 5 HALT) of instruction x.
    function automatic logic [13:0] exp_ctrl(input int ph, input logic rdy,
                                             input logic [31:0] x, input logic z);
        kind_t k = kind_of(x);
        logic mreq = 1'b0, we = 1'b0, asel = 1'b0, pw = 1'b0, asb = 1'b0, rw = 1'b0;
        logic [1:0] ps = 2'd0, wb = 2'd0;
        logic [2:0] st = ph[2:0];
        logic taken;
        taken = (x[14:12] == 3'b001) ? !z : z;
        case (ph)
            0: mreq = 1'b1;
            2: begin
                asb = (k == K_I) || (k == K_LD) || (k == K_ST) || (k == K_JALR);
                if (k == K_BR) begin
                    pw = 1'b1;
                    ps = taken ? 2'd1 : 2'd0;
                end
            end
            3: begin
                mreq = 1'b1;
                asel = 1'b1;
                we   = (k == K_ST);
                pw   = (k == K_ST) && rdy;
            end
            4: begin
                rw = 1'b1;
                pw = 1'b1;
                case (k)
                    K_LD:   wb = 2'd1;
                    K_JAL:  begin wb = 2'd2; ps = 2'd1; end
                    K_JALR: begin wb = 2'd2; ps = 2'd2; end
                    K_LUI:  wb = 2'd3;
                    default: ;
                endcase
            end
            default: ;
        endcase
        return {st, mreq, we, asel, pw, ps, asb, rw, wb, 1'b0};
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] x = $urandom;
        case ($urandom_range(0, 7))
            0: x[6:0] = 7'b0110011;
            1: x[6:0] = 7'b0010011;
            2: x[6:0] = 7'b0000011;
            3: x[6:0] = 7'b0100011;
            4: begin x[6:0] = 7'b1100011; x[14:13] = 2'b00; end
            5: x[6:0] = 7'b1101111;
            6: x[6:0] = 7'b1100111;
            default: x[6:0] = 7'b0110111;
        endcase
        return x;
    endfunction

    // Run one legal instruction through the controller: fw fetch waits, mw memory waits.
    task automatic run_instr(input logic [31:0] ins, input int fw, input int mw, input logic z);
        int         ph_q[$];
        logic       rdy_q[$];
        kind_t      k = kind_of(ins);
        int         pw_cnt = 0;
        int         rw_cnt = 0;
        logic [13:0] e;
        for (int i = 0; i < fw; i++) begin ph_q.push_back(0); rdy_q.push_back(1'b0); end
        ph_q.push_back(0); rdy_q.push_back(1'b1);
        ph_q.push_back(1); rdy_q.push_back(1'($urandom));
        ph_q.push_back(2); rdy_q.push_back(1'($urandom));
        if (k == K_LD || k == K_ST) begin
            for (int i = 0; i < mw; i++) begin ph_q.push_back(3); rdy_q.push_back(1'b0); end
            ph_q.push_back(3); rdy_q.push_back(1'b1);
        end
        if (k != K_BR && k != K_ST) begin ph_q.push_back(4); rdy_q.push_back(1'($urandom)); end
        obs_mem_cycles = 0;
        obs_rw = 1'b0;
        foreach (ph_q[i]) begin
            @(negedge clk);
            mem_ready = rdy_q[i];
            instr     = (ph_q[i] == 0 && rdy_q[i]) ? ins : $urandom;
            alu_zero  = (ph_q[i] == 2) ? z : 1'($urandom);
            #1;
            e = exp_ctrl(ph_q[i], rdy_q[i], ins, z);
            vectors++;
            if (ctrl !== e) begin
                miscompares++;
                $display("FAIL ctrl ins=%h phase=%0d: got %b want %b", ins, ph_q[i], ctrl, e);
            end
            vectors++;
            if ({ir, opcode, imm_input, imm_input_uj} !== {model_ir, model_ir[6:0], exp_imm(model_ir)}) begin
                miscompares++;
                $display("FAIL ir/imm ins=%h phase=%0d: got ir=%h imm=%h uj=%h want ir=%h imm/uj=%h",
                         ins, ph_q[i], ir, imm_input, imm_input_uj, model_ir, exp_imm(model_ir));
            end
            if (ph_q[i] == 0 && rdy_q[i]) model_ir = ins;
            if (ph_q[i] == 1) begin obs_imm12 = imm_input; obs_imm20 = imm_input_uj; obs_opc = opcode; end
            if (ph_q[i] == 2) obs_asb = alu_src_b;
            if (state == 3'd3) obs_mem_cycles++;
            if (pc_write) begin obs_wb = wb_sel; obs_ps = pc_src; end
            if (reg_write) obs_rw = 1'b1;
            pw_cnt += int'(pc_write);
            rw_cnt += int'(reg_write);
        end
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        vectors++;
        if (ctrl !== exp_ctrl(0, 1'b0, ins, z)) begin
            miscompares++;
            $display("FAIL return_to_fetch ins=%h: got %b want %b", ins, ctrl, exp_ctrl(0, 1'b0, ins, z));
        end
        vectors++;
        if (pw_cnt != 1 || rw_cnt != ((k != K_BR && k != K_ST) ? 1 : 0)) begin
            miscompares++;
            $display("FAIL pulse_count ins=%h: got pc_write=%0d reg_write=%0d want 1/%0d",
                     ins, pw_cnt, rw_cnt, (k != K_BR && k != K_ST) ? 1 : 0);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        #1;
        vectors++;
        if (ctrl !== 14'd0 || ir !== 32'h0000_0013) begin
            miscompares++;
            $display("FAIL reset_state: got ctrl=%b ir=%h want ctrl=0 ir=00000013", ctrl, ir);
        end
        @(negedge clk);
        reset = 1'b0;
        mem_ready = 1'b0;
        #1;
        vectors++;
        if (ctrl !== exp_ctrl(0, 1'b0, 32'h13, 1'b0)) begin
            miscompares++;
            $display("FAIL reset_release_fetch: got %b want %b", ctrl, exp_ctrl(0, 1'b0, 32'h13, 1'b0));
        end
        model_ir = 32'h0000_0013;
    endtask

    task automatic test_addi();
        run_instr(32'h0050_0093, 0, 0, 1'b0);
        vectors++;
        if (obs_imm12 !== 12'h005 || obs_opc !== 7'b0010011 || obs_asb !== 1'b1 ||
            obs_wb !== 2'd0 || obs_ps !== 2'd0 || obs_rw !== 1'b1) begin
            miscompares++;
            $display("FAIL addi_fields: got imm=%h opc=%b asb=%b wb=%0d ps=%0d rw=%b want 005/0010011/1/0/0/1",
                     obs_imm12, obs_opc, obs_asb, obs_wb, obs_ps, obs_rw);
        end
    endtask

    task automatic test_branch();
        run_instr(32'h0000_0463, 0, 0, 1'b1);
        vectors++;
        if (obs_imm12 !== 12'h004 || obs_ps !== 2'd1 || obs_rw !== 1'b0) begin
            miscompares++;
            $display("FAIL beq_taken: got imm=%h ps=%0d rw=%b want 004/1/0", obs_imm12, obs_ps, obs_rw);
        end
        run_instr(32'h0000_0463, 1, 0, 1'b0);
        vectors++;
        if (obs_ps !== 2'd0) begin
            miscompares++;
            $display("FAIL beq_not_taken: got ps=%0d want 0", obs_ps);
        end
    endtask

    task automatic test_load_stall();
        run_instr(32'h0040_A103, 0, 3, 1'b0);
        vectors++;
        if (obs_mem_cycles != 4 || obs_wb !== 2'd1 || obs_rw !== 1'b1) begin
            miscompares++;
            $display("FAIL lw_stall: got mem_cycles=%0d wb=%0d rw=%b want 4/1/1", obs_mem_cycles, obs_wb, obs_rw);
        end
    endtask

    task automatic test_jal();
        run_instr(32'hFFDF_F0EF, 0, 0, 1'b0);
        vectors++;
        if (obs_imm20 !== 20'hFFFFE || obs_wb !== 2'd2 || obs_ps !== 2'd1 || obs_rw !== 1'b1) begin
            miscompares++;
            $display("FAIL jal: got uj=%h wb=%0d ps=%0d rw=%b want FFFFE/2/1/1", obs_imm20, obs_wb, obs_ps, obs_rw);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++)
            run_instr(rand_instr(), $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom));
    endtask

    task automatic test_reset_mid_stall();
        @(negedge clk);
        mem_ready = 1'b1;
        instr = 32'h0040_A103;
        @(negedge clk);
        mem_ready = 1'b0;
        @(negedge clk);
        alu_zero = 1'b0;
        @(negedge clk);
        #1;
        vectors++;
        if (ctrl !== exp_ctrl(3, 1'b0, 32'h0040_A103, 1'b0)) begin
            miscompares++;
            $display("FAIL stall_in_mem: got %b want %b", ctrl, exp_ctrl(3, 1'b0, 32'h0040_A103, 1'b0));
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        vectors++;
        if ({mem_req, mem_we, mem_addr_sel, pc_write, pc_src, alu_src_b, reg_write, wb_sel} !== 10'd0) begin
            miscompares++;
            $display("FAIL reset_strobes: got %b want 0",
                     {mem_req, mem_we, mem_addr_sel, pc_write, pc_src, alu_src_b, reg_write, wb_sel});
        end
        @(negedge clk);
        #1;
        vectors++;
        if (ctrl !== 14'd0 || ir !== 32'h0000_0013) begin
            miscompares++;
            $display("FAIL mid_stall_reset_state: got ctrl=%b ir=%h want 0/00000013", ctrl, ir);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        vectors++;
        if (ctrl !== exp_ctrl(0, 1'b0, 32'h13, 1'b0)) begin
            miscompares++;
            $display("FAIL mid_stall_release: got %b want %b", ctrl, exp_ctrl(0, 1'b0, 32'h13, 1'b0));
        end
        model_ir = 32'h0000_0013;
    endtask

    task automatic test_illegal();
        @(negedge clk);
        mem_ready = 1'b1;
        instr = 32'h0000_007F;
        #1;
        vectors++;
        if (ctrl !== exp_ctrl(0, 1'b1, 32'h7F, 1'b0)) begin
            miscompares++;
            $display("FAIL illegal_fetch: got %b want %b", ctrl, exp_ctrl(0, 1'b1, 32'h7F, 1'b0));
        end
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        vectors++;
        if (ctrl !== {3'd1, 11'd0} || ir !== 32'h0000_007F) begin
            miscompares++;
            $display("FAIL illegal_decode: got ctrl=%b ir=%h want %b/0000007f", ctrl, ir, {3'd1, 11'd0});
        end
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            mem_ready = 1'($urandom);
            alu_zero  = 1'($urandom);
            #1;
            vectors++;
            if (ctrl !== {3'd5, 10'd0, 1'b1}) begin
                miscompares++;
                $display("FAIL halt_cycle%0d: got %b want %b", c, ctrl, {3'd5, 10'd0, 1'b1});
            end
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        mem_ready = 1'b0;
        #1;
        vectors++;
        if (ctrl !== exp_ctrl(0, 1'b0, 32'h13, 1'b0) || ir !== 32'h0000_0013) begin
            miscompares++;
            $display("FAIL halt_reset_exit: got ctrl=%b ir=%h want %b/00000013",
                     ctrl, ir, exp_ctrl(0, 1'b0, 32'h13, 1'b0));
        end
        model_ir = 32'h0000_0013;
    endtask

    initial begin
        reset     = 1'b1;
        mem_ready = 1'b0;
        instr     = '0;
        alu_zero  = 1'b0;
        model_ir  = 32'h0000_0013;
        repeat (2) @(posedge clk);
        test_reset();
        test_addi();
        test_branch();
        test_load_stall();
        test_jal();
        test_random();
        test_reset_mid_stall();
        run_instr(32'h0040_A103, 0, 0, 1'b0);
        test_illegal();
        run_instr(32'h1234_50B7, 2, 0, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
